// File: rtl/logisim_input_conditioner.sv
// Per-channel pin conditioner: two-flop synchroniser, debounce FSM with stability
// counter, registered clean level, rise/fall pulses and a press-toggle bit.
//
// state   | meaning
// STABLE0 | accepted level 0, watching for a 1
// WAIT1   | sync value 1, counting towards acceptance of 1
// STABLE1 | accepted level 1, watching for a 0
// WAIT0   | sync value 0, counting towards acceptance of 0
module logisim_input_conditioner #(
    parameter int NrOfInputs  = 5,
    parameter int NrOfBits    = 20,
    parameter int StableCount = 500000
) (
    input  logic                  FPGA_GlobalClock,
    input  logic                  RST,
    input  logic [NrOfInputs-1:0] RawIn,
    output logic [NrOfInputs-1:0] Level,
    output logic [NrOfInputs-1:0] RisePulse,
    output logic [NrOfInputs-1:0] FallPulse,
    output logic [NrOfInputs-1:0] Toggle
);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        WAIT1   = 2'd1,
        STABLE1 = 2'd2,
        WAIT0   = 2'd3
    } state_t;

    localparam logic [NrOfBits-1:0] CNT_LAST = NrOfBits'(StableCount - 1);
    localparam logic [NrOfBits-1:0] CNT_ONE  = NrOfBits'(1);

    logic [NrOfInputs-1:0] sync1_q;
    logic [NrOfInputs-1:0] sync2_q;

    always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= RawIn;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NrOfInputs; g++) begin : g_ch
        state_t              state_q, state_d;
        logic [NrOfBits-1:0] cnt_q, cnt_d;
        logic                level_q, level_d;
        logic                rise_q, rise_d;
        logic                fall_q, fall_d;
        logic                toggle_q, toggle_d;
        logic                in_s;

        assign in_s = sync2_q[g];

        always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
            if (RST) begin
                state_q  <= STABLE0;
                cnt_q    <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                toggle_q <= toggle_d;
            end
        end

        // The sync value is tested before the count, so a bounce on the final
        // counting cycle still rejects.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                STABLE0: begin
                    if (in_s) begin
                        state_d = WAIT1;
                        cnt_d   = '0;
                    end
                end
                WAIT1: begin
                    if (!in_s)                 state_d = STABLE0;
                    else if (cnt_q == CNT_LAST) state_d = STABLE1;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                STABLE1: begin
                    if (!in_s) begin
                        state_d = WAIT0;
                        cnt_d   = '0;
                    end
                end
                WAIT0: begin
                    if (in_s)                  state_d = STABLE1;
                    else if (cnt_q == CNT_LAST) state_d = STABLE0;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                default: begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            rise_d   = (state_q == WAIT1) && in_s && (cnt_q == CNT_LAST);
            fall_d   = (state_q == WAIT0) && !in_s && (cnt_q == CNT_LAST);
            level_d  = (state_d == STABLE1) || (state_d == WAIT0);
            toggle_d = toggle_q ^ rise_d;
        end

        assign Level[g]     = level_q;
        assign RisePulse[g] = rise_q;
        assign FallPulse[g] = fall_q;
        assign Toggle[g]    = toggle_q;
    end

endmodule

// File: tb/tb_logisim_input_conditioner.sv
// Randomised scoreboard bench for logisim_input_conditioner: a run-length model
// predicts each accepted edge; a monitor matches every pulse cycle against it.
module tb_logisim_input_conditioner;

    localparam int N  = 5;
    localparam int NB = 3;
    localparam int SC = 4;

    typedef struct {
        int       e;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] lvl;
        logic [N-1:0] tog;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '1;
    logic [N-1:0] level, rise_p, fall_p, tog;

    int  checks = 0;
    int  errors = 0;
    int  edge_n = 0;
    bit  done   = 1'b0;
    ev_t q[$];

    logic [N-1:0] mlvl = '0;
    logic [N-1:0] mtog = '0;
    int           run[N];

    logisim_input_conditioner #(
        .NrOfInputs (N),
        .NrOfBits   (NB),
        .StableCount(SC)
    ) dut (
        .FPGA_GlobalClock(clk),
        .RST             (rst),
        .RawIn           (raw),
        .Level           (level),
        .RisePulse       (rise_p),
        .FallPulse       (fall_p),
        .Toggle          (tog)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once SC+1 consecutive pin samples differ
    // from the current level; the outputs show it two edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mlvl = '0;
            mtog = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
            q.delete();
        end else begin
            logic [N-1:0] r, f;
            edge_n++;
            r = '0;
            f = '0;
            for (int i = 0; i < N; i++) begin
                if (raw[i] != mlvl[i]) run[i]++;
                else                   run[i] = 0;
                if (run[i] == SC + 1) begin
                    run[i]  = 0;
                    mlvl[i] = ~mlvl[i];
                    if (mlvl[i]) begin
                        r[i]    = 1'b1;
                        mtog[i] = ~mtog[i];
                    end else begin
                        f[i] = 1'b1;
                    end
                end
            end
            if ((r | f) != '0) q.push_back('{edge_n + 2, r, f, mlvl, mtog});
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                checks++;
                if ({level, rise_p, fall_p, tog} !== '0) begin
                    errors++;
                    $display("FAIL reset_clear: lvl=%b rise=%b fall=%b tog=%b want all 0",
                             level, rise_p, fall_p, tog);
                end
            end else begin
                while (q.size() > 0 && q[0].e < edge_n) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_pulse: edge %0d rise=%b fall=%b never seen",
                             q[0].e, q[0].rise, q[0].fall);
                    void'(q.pop_front());
                end
                if ((rise_p | fall_p) != '0 || (q.size() > 0 && q[0].e == edge_n)) begin
                    checks++;
                    if (q.size() == 0 || q[0].e != edge_n) begin
                        errors++;
                        $display("FAIL unexpected_pulse: edge %0d rise=%b fall=%b want none",
                                 edge_n, rise_p, fall_p);
                    end else begin
                        if (rise_p !== q[0].rise || fall_p !== q[0].fall ||
                            level !== q[0].lvl || tog !== q[0].tog) begin
                            errors++;
                            $display("FAIL pulse_edge%0d: rise=%b fall=%b lvl=%b tog=%b want rise=%b fall=%b lvl=%b tog=%b",
                                     edge_n, rise_p, fall_p, level, tog,
                                     q[0].rise, q[0].fall, q[0].lvl, q[0].tog);
                        end
                        void'(q.pop_front());
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d events left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(3);
        raw = '0;
        tick(1);
        #2 rst = 1'b0;

        // clean press on channel 0
        tick(2);
        raw[0] = 1'b1;
        tick(12);

        // bounce on channel 1: 3 high, 1 low, 3 high, low
        for (int i = 0; i < 8; i++) begin
            raw[1] = (i == 3 || i == 7) ? 1'b0 : 1'b1;
            tick(1);
        end
        tick(10);

        // release, then a second full press on channel 0
        raw[0] = 1'b0;
        tick(12);
        raw[0] = 1'b1;
        tick(12);

        // two channels on the same edge
        raw[2] = 1'b1;
        raw[4] = 1'b1;
        tick(12);

        // reset while channel 3 is mid-count (cnt = 2)
        raw[3] = 1'b1;
        tick(5);
        #2 rst = 1'b1;
        tick(2);
        #2 rst = 1'b0;
        tick(14);

        // randomised pins with bounce
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
            tick(1);
        end
        tick(20);
        done = 1'b1;
    end

endmodule
